// File: rtl/nibble_gearbox_10to4.sv
// Width down-converter: 10-bit words in, the same bit stream out LSB-first as 4-bit nibbles.
// Valid/ready on both sides; a flush pulse zero-pads a trailing partial nibble.
module nibble_gearbox_10to4 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] nib_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [15:0]      bit_buf, bit_buf_next;
  logic [4:0]       count, count_next;
  logic [CNT_W-1:0] nib_cnt_q;

  logic             push, pop;
  logic [15:0]      shifted;
  logic [15:0]      word_ext;
  logic [4:0]       base;

  // Ready is held low throughout a flush so no new bits can join the padded residue.
  assign in_ready  = !rst && (state == IDLE) && (count <= 5'd6);
  assign out_valid = !rst && (count >= 5'd4);
  assign out_data  = rst ? 4'h0 : bit_buf[3:0];
  assign busy      = !rst && ((count != 5'd0) || (state == FLUSH));
  assign nib_count = nib_cnt_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    shifted      = pop ? {4'h0, bit_buf[15:4]} : bit_buf;
    base         = pop ? (count - 5'd4) : count;
    word_ext     = {6'h00, in_data};
    bit_buf_next = shifted;
    count_next   = base;

    // A push lands right after the surviving bits; base never exceeds 6 here.
    if (push) begin
      bit_buf_next = shifted | (word_ext << base);
      count_next   = base + 5'd10;
    end

    case (state)
      IDLE: begin
        if (flush) state_next = FLUSH;
      end
      FLUSH: begin
        // Bits above count are already zero, so padding is just a count bump.
        if (count == 5'd0)     state_next = IDLE;
        else if (count < 5'd4) count_next = 5'd4;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_buf   <= 16'h0000;
      count     <= 5'd0;
      nib_cnt_q <= '0;
    end else begin
      state     <= state_next;
      bit_buf   <= bit_buf_next;
      count     <= count_next;
      if (pop) nib_cnt_q <= nib_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_nibble_gearbox_10to4.sv
// Self-checking bench for nibble_gearbox_10to4: a bit-queue scoreboard fed on every push/flush,
// drained on every pop, plus directed checks for reset, flush, backpressure and counter wrap.
module tb_nibble_gearbox_10to4;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [9:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic             busy;
  logic [CNT_W-1:0] nib_count;

  nibble_gearbox_10to4 #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .busy      (busy),
    .nib_count (nib_count)
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  bit         bits[$];
  logic [3:0] exp_q[$];
  int         nib_exp     = 0;
  int         pop_total   = 0;
  bit         last_push   = 0;
  bit         hold_pend   = 0;
  logic [3:0] hold_data   = 4'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Move whole nibbles from the reference bit stream into the expected-output queue.
  task automatic pack_nibbles();
    logic [3:0] n;
    while (bits.size() >= 4) begin
      for (int i = 0; i < 4; i++) n[i] = bits.pop_front();
      exp_q.push_back(n);
    end
  endtask

  // Inputs are set at the falling edge; this samples 1 ns later, clocks one rising edge,
  // and returns at the next falling edge.
  task automatic tick();
    bit chk12;
    #1;
    chk12     = 0;
    last_push = 0;
    if (rst) begin
      bits.delete();
      exp_q.delete();
      nib_exp   = 0;
      hold_pend = 0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
      end
      last_push = in_valid && in_ready;
      chk12     = last_push && out_valid && out_ready && (dut.count == 5'd6);
      if (out_valid && out_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("nibble", out_data, exp_q.pop_front());
        nib_exp++;
        pop_total++;
      end
      if (last_push) begin
        for (int i = 0; i < 10; i++) bits.push_back(in_data[i]);
        pack_nibbles();
      end
      if (flush) begin
        while (bits.size() % 4 != 0) bits.push_back(1'b0);
        pack_nibbles();
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
    end
    @(posedge clk);
    @(negedge clk);
    check("nib_count", nib_count, nib_exp % (1 << CNT_W));
    if (chk12) check("simul_count", dut.count, 12);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", busy, 0);
    check("sb_empty", exp_q.size(), 0);
  endtask

  task automatic flush_drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle(budget);
  endtask

  initial begin
    int words;
    int n;
    int start_pops;
    int pushed;

    rst       = 1'b1;
    in_data   = 10'h000;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(negedge clk);

    // Reset: everything quiet while rst is high, and the stream idle after release.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();
    check("post_rst_count", dut.count, 0);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Basic pack: 0x3A5 then 0x001 -> 5, A, 7, 0, 0.
    in_valid = 1'b1;
    in_data  = 10'h3A5;
    tick();
    check("basic_in_ready_c10", in_ready, 0);
    check("basic_first_valid", out_valid, 1);
    check("basic_first_nib", out_data, 4'h5);
    in_data = 10'h001;
    tick();
    check("basic_c6_in_ready", in_ready, 1);
    check("basic_second_nib", out_data, 4'hA);
    tick();
    in_valid = 1'b0;
    check("basic_c12", dut.count, 12);
    check("basic_third_nib", out_data, 4'h7);
    wait_idle(20);
    check("basic_end_count", dut.count, 0);
    check("basic_nib_count", nib_count, 5);

    // Flush residue: 0x3A5 drained to two bits, then padded to nibble 0x3.
    in_valid = 1'b1;
    in_data  = 10'h3A5;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("fl_residue_count", dut.count, 2);
    check("fl_residue_valid", out_valid, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_in_ready_low", in_ready, 0);
    check("fl_busy", busy, 1);
    tick();
    check("fl_pad_valid", out_valid, 1);
    check("fl_pad_nib", out_data, 4'h3);
    tick();
    check("fl_still_busy", busy, 1);
    tick();
    check("fl_idle_busy", busy, 0);
    check("fl_idle_in_ready", in_ready, 1);

    // Backpressure: 0x3FF with out_ready low, second word stalls, 0xF held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 10'h3FF;
    tick();
    in_data = 10'h155;
    check("bp_count", dut.count, 10);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_out_data", out_data, 4'hF);
      tick();
    end
    check("bp_stalled_count", dut.count, 10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_c6_in_ready", in_ready, 1);
    check("bp_second_nib", out_data, 4'hF);
    tick();
    check("bp_c2", dut.count, 2);
    check("bp_c2_in_ready", in_ready, 1);
    check("bp_c2_out_valid", out_valid, 0);
    in_valid = 1'b1;
    in_data  = 10'h155;
    tick();
    wait_idle(20);

    // Reset mid-stream at count 8, with a push held during reset.
    in_valid = 1'b1;
    in_data  = 10'h2C7;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 10'h0F0;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("mid_count8", dut.count, 8);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 10'h3FF;
    out_ready = 1'b1;
    tick();
    check("mid_out_valid", out_valid, 0);
    check("mid_count", dut.count, 0);
    check("mid_nib_count", nib_count, 0);
    check("mid_busy", busy, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    check("mid_no_capture", dut.count, 0);
    check("mid_no_valid", out_valid, 0);

    // Wrap: 17 pops on a 4-bit counter leave it at 1.
    start_pops = pop_total;
    pushed     = 0;
    n          = 0;
    out_ready  = 1'b1;
    while (pop_total - start_pops < 17 && n < 200) begin
      in_valid = (pushed < 7);
      in_data  = 10'($urandom);
      tick();
      if (last_push) pushed++;
      n++;
    end
    check("wrap_pops", pop_total - start_pops, 17);
    check("wrap_nib_count", nib_count, 1);
    flush_drain(40);

    // Random traffic: 1000 words, random valid/ready, occasional flush.
    words = 0;
    n     = 0;
    while (words < 1000 && n < 20000) begin
      in_valid  = ($urandom_range(2) != 0);
      in_data   = 10'($urandom);
      out_ready = ($urandom_range(3) != 0);
      flush     = !in_valid && ($urandom_range(39) == 0);
      tick();
      if (last_push) words++;
      n++;
    end
    check("rand_words", words, 1000);
    flush_drain(100);
    check("rand_bits_left", bits.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
